// File: rtl/mem_wb_bus_if_pkg.sv
// Shared constants for the Wishbone master bridges on the data and
// instruction sides: bus FSM state encodings and stall-vector bit indices.
package mem_wb_bus_if_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE       = 2'b00,
        BUS_BUSY       = 2'b01,
        BUS_WAIT_STALL = 2'b10
    } bus_state_e;

    // Stall vector layout {wb,mem,ex,id,if,pc}
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_MEM = 4;

endpackage

// File: rtl/mem_wb_bus_if.sv
// Wishbone B3 master bridge for the MEM stage: turns a single-cycle data
// request into one classic read/write cycle, stalls the pipeline while it is
// outstanding and returns (and holds) read data.
// Ports: clk, rst (async, active-low), stall_i/flush_i (pipeline control),
// cpu_* (MEM-side request/response), stallreq_o, wishbone_* (master side).
module mem_wb_bus_if
    import mem_wb_bus_if_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STALL_BIT  = STALL_MEM
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall_i,
    input  logic                    flush_i,
    input  logic                    cpu_ce_i,
    input  logic                    cpu_we_i,
    input  logic [DATA_WIDTH/8-1:0] cpu_sel_i,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]   cpu_data_i,
    output logic [DATA_WIDTH-1:0]   cpu_data_o,
    output logic                    stallreq_o,
    output logic [ADDR_WIDTH-1:0]   wishbone_addr_o,
    output logic [DATA_WIDTH-1:0]   wishbone_data_o,
    output logic                    wishbone_we_o,
    output logic [DATA_WIDTH/8-1:0] wishbone_sel_o,
    output logic                    wishbone_stb_o,
    output logic                    wishbone_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wishbone_data_i,
    input  logic                    wishbone_ack_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    bus_state_e              state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    we_q;
    logic [SEL_WIDTH-1:0]    sel_q;
    logic                    stb_q;
    logic                    cyc_q;
    logic [DATA_WIDTH-1:0]   rd_buf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= BUS_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            rd_buf_q <= '0;
        end else begin
            unique case (state_q)
                BUS_IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        addr_q  <= cpu_addr_i;
                        data_q  <= cpu_data_i;
                        we_q    <= cpu_we_i;
                        sel_q   <= cpu_sel_i;
                        stb_q   <= 1'b1;
                        cyc_q   <= 1'b1;
                        state_q <= BUS_BUSY;
                    end else begin
                        addr_q <= '0;
                        data_q <= '0;
                        we_q   <= 1'b0;
                        sel_q  <= '0;
                        stb_q  <= 1'b0;
                        cyc_q  <= 1'b0;
                    end
                end
                BUS_BUSY: begin
                    if (flush_i) begin
                        // Flush wins over a same-cycle ack
                        addr_q   <= '0;
                        data_q   <= '0;
                        we_q     <= 1'b0;
                        sel_q    <= '0;
                        stb_q    <= 1'b0;
                        cyc_q    <= 1'b0;
                        rd_buf_q <= '0;
                        state_q  <= BUS_IDLE;
                    end else if (wishbone_ack_i) begin
                        addr_q   <= '0;
                        data_q   <= '0;
                        we_q     <= 1'b0;
                        sel_q    <= '0;
                        stb_q    <= 1'b0;
                        cyc_q    <= 1'b0;
                        rd_buf_q <= wishbone_data_i;
                        state_q  <= stall_i[STALL_BIT] ? BUS_WAIT_STALL
                                                       : BUS_IDLE;
                    end
                end
                BUS_WAIT_STALL: begin
                    if (flush_i) begin
                        rd_buf_q <= '0;
                        state_q  <= BUS_IDLE;
                    end else if (!stall_i[STALL_BIT]) begin
                        state_q <= BUS_IDLE;
                    end
                end
                default: begin
                    state_q <= BUS_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = rd_buf_q;
        unique case (state_q)
            BUS_IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
            end
            BUS_BUSY: begin
                // Ack releases the stall in the same cycle
                stallreq_o = ~wishbone_ack_i & ~flush_i;
                cpu_data_o = wishbone_ack_i ? wishbone_data_i : '0;
            end
            default: begin
                stallreq_o = 1'b0;
            end
        endcase
    end

    assign wishbone_addr_o = addr_q;
    assign wishbone_data_o = data_q;
    assign wishbone_we_o   = we_q;
    assign wishbone_sel_o  = sel_q;
    assign wishbone_stb_o  = stb_q;
    assign wishbone_cyc_o  = cyc_q;

endmodule

// File: tb/tb_mem_wb_bus_if.sv
// Directed testbench for mem_wb_bus_if.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_mem_wb_bus_if;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic [31:0] wb_addr;
    logic [31:0] wb_dato;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_cyc;
    logic [31:0] wb_dati;
    logic        wb_ack;

    int errors = 0;
    int checks = 0;

    mem_wb_bus_if dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .cpu_ce_i        (cpu_ce_i),
        .cpu_we_i        (cpu_we_i),
        .cpu_sel_i       (cpu_sel_i),
        .cpu_addr_i      (cpu_addr_i),
        .cpu_data_i      (cpu_data_i),
        .cpu_data_o      (cpu_data_o),
        .stallreq_o      (stallreq_o),
        .wishbone_addr_o (wb_addr),
        .wishbone_data_o (wb_dato),
        .wishbone_we_o   (wb_we),
        .wishbone_sel_o  (wb_sel),
        .wishbone_stb_o  (wb_stb),
        .wishbone_cyc_o  (wb_cyc),
        .wishbone_data_i (wb_dati),
        .wishbone_ack_i  (wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        stall_i    = '0;
        flush_i    = 1'b0;
        cpu_ce_i   = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = '0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        wb_dati    = '0;
        wb_ack     = 1'b0;

        // Reset state
        #12;
        check("rst_stb", {31'd0, wb_stb}, 32'd0);
        check("rst_cyc", {31'd0, wb_cyc}, 32'd0);
        check("rst_addr", wb_addr, 32'd0);
        check("rst_dout", cpu_data_o, 32'd0);
        check("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
        tick();
        rst = 1'b1;

        // Read, zero-wait slave
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h100; cpu_sel_i = 4'hF;
        settle();
        check("rd0_req_stall", {31'd0, stallreq_o}, 32'd1);
        check("rd0_req_stb", {31'd0, wb_stb}, 32'd0);
        tick();
        cpu_ce_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0;
        wb_ack = 1'b1; wb_dati = 32'hDEADBEEF;
        settle();
        check("rd0_stb", {31'd0, wb_stb}, 32'd1);
        check("rd0_cyc", {31'd0, wb_cyc}, 32'd1);
        check("rd0_addr", wb_addr, 32'h100);
        check("rd0_sel", {28'd0, wb_sel}, 32'hF);
        check("rd0_ack_stall", {31'd0, stallreq_o}, 32'd0);
        check("rd0_ack_data", cpu_data_o, 32'hDEADBEEF);
        tick();
        wb_ack = 1'b0; wb_dati = '0;
        settle();
        check("rd0_after_stb", {31'd0, wb_stb}, 32'd0);
        check("rd0_after_addr", wb_addr, 32'd0);
        check("rd0_hold_data", cpu_data_o, 32'hDEADBEEF);
        tick();

        // Write, 3 wait states
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_sel_i = 4'b0100;
        cpu_addr_i = 32'h300; cpu_data_i = 32'h00AB0000;
        settle();
        check("wr_req_stall", {31'd0, stallreq_o}, 32'd1);
        tick();
        cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_sel_i = '0;
        cpu_addr_i = '0; cpu_data_i = '0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("wr_wait_we", {31'd0, wb_we}, 32'd1);
            check("wr_wait_sel", {28'd0, wb_sel}, 32'h4);
            check("wr_wait_data", wb_dato, 32'h00AB0000);
            check("wr_wait_stall", {31'd0, stallreq_o}, 32'd1);
            tick();
        end
        wb_ack = 1'b1; wb_dati = 32'h11112222;
        settle();
        check("wr_ack_we", {31'd0, wb_we}, 32'd1);
        check("wr_ack_addr", wb_addr, 32'h300);
        check("wr_ack_stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        wb_ack = 1'b0; wb_dati = '0;
        settle();
        check("wr_done_we", {31'd0, wb_we}, 32'd0);
        check("wr_done_sel", {28'd0, wb_sel}, 32'd0);
        check("wr_done_data", wb_dato, 32'd0);
        check("wr_rdbuf", cpu_data_o, 32'h11112222);
        tick();

        // Flush while BUSY
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h200; cpu_sel_i = 4'hF;
        settle();
        tick();
        cpu_ce_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0;
        settle();
        check("fl_busy_stall", {31'd0, stallreq_o}, 32'd1);
        check("fl_busy_stb", {31'd0, wb_stb}, 32'd1);
        tick();
        flush_i = 1'b1;
        settle();
        check("fl_stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        flush_i = 1'b0; wb_ack = 1'b1; wb_dati = 32'h55555555;
        settle();
        check("fl_stb", {31'd0, wb_stb}, 32'd0);
        check("fl_cyc", {31'd0, wb_cyc}, 32'd0);
        check("fl_late_ack_data", cpu_data_o, 32'd0);
        check("fl_late_ack_stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        wb_ack = 1'b0; wb_dati = '0;
        settle();
        check("fl_rdbuf", cpu_data_o, 32'd0);
        check("fl_stb2", {31'd0, wb_stb}, 32'd0);
        tick();

        // Ack during external MEM stall
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h400; cpu_sel_i = 4'hF;
        settle();
        tick();
        cpu_ce_i = 1'b0;
        wb_ack = 1'b1; wb_dati = 32'hCAFEF00D; stall_i = 6'b010000;
        settle();
        check("xs_ack_data", cpu_data_o, 32'hCAFEF00D);
        check("xs_ack_stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        wb_ack = 1'b0; wb_dati = 32'hBAD0BAD0;
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h404;
        settle();
        check("xs_w1_stall", {31'd0, stallreq_o}, 32'd0);
        check("xs_w1_data", cpu_data_o, 32'hCAFEF00D);
        tick();
        settle();
        check("xs_w2_stb", {31'd0, wb_stb}, 32'd0);
        check("xs_w2_data", cpu_data_o, 32'hCAFEF00D);
        tick();
        stall_i = '0; cpu_ce_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0;
        settle();
        check("xs_w3_data", cpu_data_o, 32'hCAFEF00D);
        check("xs_w3_stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        wb_dati = '0;
        settle();
        check("xs_idle_stb", {31'd0, wb_stb}, 32'd0);
        check("xs_idle_data", cpu_data_o, 32'hCAFEF00D);
        tick();

        // Asynchronous reset mid-BUSY
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h500; cpu_sel_i = 4'hF;
        settle();
        tick();
        cpu_ce_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0;
        #2;
        check("ar_pre_stb", {31'd0, wb_stb}, 32'd1);
        rst = 1'b0;
        #1;
        check("ar_stb", {31'd0, wb_stb}, 32'd0);
        check("ar_cyc", {31'd0, wb_cyc}, 32'd0);
        check("ar_addr", wb_addr, 32'd0);
        check("ar_sel", {28'd0, wb_sel}, 32'd0);
        check("ar_data", cpu_data_o, 32'd0);
        tick();
        rst = 1'b1;
        wb_ack = 1'b1; wb_dati = 32'h77777777;
        settle();
        check("ar_ack_stb", {31'd0, wb_stb}, 32'd0);
        check("ar_ack_data", cpu_data_o, 32'd0);
        check("ar_ack_stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        wb_ack = 1'b0; wb_dati = '0;
        settle();
        check("ar_idle_data", cpu_data_o, 32'd0);
        tick();

        // Back-to-back loads with ce held high
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h600; cpu_sel_i = 4'hF;
        settle();
        check("bb1_req_stall", {31'd0, stallreq_o}, 32'd1);
        tick();
        wb_ack = 1'b1; wb_dati = 32'h11111111;
        settle();
        check("bb1_addr", wb_addr, 32'h600);
        check("bb1_data", cpu_data_o, 32'h11111111);
        tick();
        wb_ack = 1'b0; wb_dati = '0; cpu_addr_i = 32'h604;
        settle();
        check("bb_gap_stb", {31'd0, wb_stb}, 32'd0);
        check("bb_gap_stall", {31'd0, stallreq_o}, 32'd1);
        check("bb_gap_data", cpu_data_o, 32'h11111111);
        tick();
        cpu_ce_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0;
        wb_ack = 1'b1; wb_dati = 32'h22222222;
        settle();
        check("bb2_stb", {31'd0, wb_stb}, 32'd1);
        check("bb2_addr", wb_addr, 32'h604);
        check("bb2_data", cpu_data_o, 32'h22222222);
        tick();
        wb_ack = 1'b0; wb_dati = '0;
        settle();
        check("bb2_done_stb", {31'd0, wb_stb}, 32'd0);
        check("bb2_hold", cpu_data_o, 32'h22222222);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
